// File: rtl/pa_noc.sv
// NoC-wide constants shared by router blocks and their benches.
package pa_noc;
    localparam int APB_PACKET_WIDTH = 16;
endpackage

// File: rtl/router_output_arbiter_if.sv
// Bundle between N_REQ input sources and one registered router output port.
interface router_output_arbiter_if #(
    parameter int N_REQ = 5,
    parameter int W     = pa_noc::APB_PACKET_WIDTH
);
    localparam int IDX_WIDTH = $clog2(N_REQ);

    logic [N_REQ*W-1:0]   i_reqPacket;
    logic [N_REQ-1:0]     i_reqValid;
    logic [N_REQ-1:0]     o_reqReady;
    logic [W-1:0]         o_packet;
    logic                 o_packetValid;
    logic                 i_packetReady;
    logic [IDX_WIDTH-1:0] o_grantIdx;

    modport slave (
        input  i_reqPacket, i_reqValid, i_packetReady,
        output o_reqReady, o_packet, o_packetValid, o_grantIdx
    );

    modport master (
        output i_reqPacket, i_reqValid, i_packetReady,
        input  o_reqReady, o_packet, o_packetValid, o_grantIdx
    );
endinterface

// File: rtl/router_output_arbiter.sv
// Round-robin N_REQ:1 output arbiter; 1-cycle grant-to-output latency, 1 pkt/cycle.
// Backpressure: output register holds while stalled and o_reqReady stays 0 until it can load.
module router_output_arbiter #(
    parameter int N_REQ = 5
) (
    input  logic                    i_clk,
    input  logic                    i_arst_n,
    router_output_arbiter_if.slave  bus
);
    localparam int APB_PACKET_WIDTH = pa_noc::APB_PACKET_WIDTH;
    localparam int IDX_WIDTH        = $clog2(N_REQ);

    logic [IDX_WIDTH-1:0]        ptr;
    logic [APB_PACKET_WIDTH-1:0] packetQ;
    logic                        packetValidQ;
    logic [IDX_WIDTH-1:0]        grantIdxQ;

    logic                        loadEn;
    logic                        xfer;
    logic                        hiHit;
    logic                        loHit;
    logic [IDX_WIDTH-1:0]        hiIdx;
    logic [IDX_WIDTH-1:0]        loIdx;
    logic [IDX_WIDTH-1:0]        grantSel;
    logic [N_REQ-1:0]            grantOh;
    logic [APB_PACKET_WIDTH-1:0] grantPkt;

    assign loadEn = !packetValidQ || bus.i_packetReady;

    // Lowest valid source at or above ptr wins; otherwise the lowest valid overall (wrap).
    always_comb begin
        hiHit = 1'b0;
        loHit = 1'b0;
        hiIdx = '0;
        loIdx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (bus.i_reqValid[k]) begin
                loHit = 1'b1;
                loIdx = IDX_WIDTH'(k);
                if (k >= int'(ptr)) begin
                    hiHit = 1'b1;
                    hiIdx = IDX_WIDTH'(k);
                end
            end
        end
    end

    assign grantSel = hiHit ? hiIdx : loIdx;
    assign xfer     = loadEn && loHit;

    always_comb begin
        grantOh  = '0;
        grantPkt = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (IDX_WIDTH'(k) == grantSel) begin
                grantOh[k] = loHit;
                grantPkt   = bus.i_reqPacket[k*APB_PACKET_WIDTH +: APB_PACKET_WIDTH];
            end
        end
    end

    // Gated by reset directly so no ready leaks out while the registers are still held.
    assign bus.o_reqReady = (xfer && i_arst_n) ? grantOh : '0;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            ptr          <= '0;
            packetQ      <= '0;
            packetValidQ <= 1'b0;
            grantIdxQ    <= '0;
        end else if (xfer) begin
            packetQ      <= grantPkt;
            packetValidQ <= 1'b1;
            grantIdxQ    <= grantSel;
            ptr          <= (grantSel == IDX_WIDTH'(N_REQ - 1)) ? '0 : grantSel + 1'b1;
        end else if (loadEn) begin
            packetQ      <= '0;
            packetValidQ <= 1'b0;
        end
    end

    assign bus.o_packet      = packetQ;
    assign bus.o_packetValid = packetValidQ;
    assign bus.o_grantIdx    = grantIdxQ;
endmodule

// File: doc/router_output_arbiter.md
ROUTER_OUTPUT_ARBITER -- requirements
Module: router_output_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 5, number of input sources sharing one router output port (0=local NI, 1=North, 2=South, 3=East, 4=West).
REQ-002 SHALL have localparam APB_PACKET_WIDTH = pa_noc::APB_PACKET_WIDTH, packet width.
REQ-003 SHALL have localparam IDX_WIDTH = $clog2(N_REQ), source index width.
REQ-004 i_clk  input  1  clock; all state updates on its rising edge.
REQ-005 i_arst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_reqPacket  input  N_REQ*APB_PACKET_WIDTH  packets, source k in bits [k*APB_PACKET_WIDTH +: APB_PACKET_WIDTH].
REQ-007 i_reqValid  input  N_REQ  per-source packet valid.
REQ-008 o_reqReady  output  N_REQ  per-source ready; one-hot or zero.
REQ-009 o_packet  output  APB_PACKET_WIDTH  registered granted packet.
REQ-010 o_packetValid  output  1  registered valid for o_packet.
REQ-011 i_packetReady  input  1  downstream ready.
REQ-012 o_grantIdx  output  IDX_WIDTH  registered source index of the packet held in o_packet.

Function
REQ-013 SHALL define loadEn = !o_packetValid || i_packetReady; output register accepts a new packet only when loadEn=1.
REQ-014 SHALL hold a round-robin pointer ptr (IDX_WIDTH bits, range 0..N_REQ-1); search order ptr, ptr+1, ..., wrapping N_REQ-1 -> 0.
REQ-015 SHALL grant the first source k in search order with i_reqValid[k]=1; o_reqReady[k] = loadEn && grant[k], combinational, all other bits 0.
REQ-016 SHALL assert no o_reqReady bit when loadEn=0 or no i_reqValid bit is set.
REQ-017 Transfer on source k = o_reqReady[k] && i_reqValid[k] at rising edge; at that edge: o_packet <= packet k, o_packetValid <= 1, o_grantIdx <= k, ptr <= (k == N_REQ-1) ? 0 : k+1.
REQ-018 SHALL leave ptr unchanged in any cycle without a transfer.
REQ-019 Downstream stall (o_packetValid=1, i_packetReady=0): o_packet, o_packetValid, o_grantIdx SHALL hold unchanged.
REQ-020 Drain without refill (loadEn=1, no transfer): o_packetValid <= 0, o_packet <= 0; o_grantIdx holds.
REQ-021 Simultaneous drain and new transfer in same cycle SHALL load the new packet with o_packetValid staying 1 (no bubble).
REQ-022 Latency: input transfer to o_packetValid = 1 cycle; sustained throughput 1 packet/cycle while i_packetReady=1.
REQ-023 Packet data on sources with i_reqValid=0 SHALL be ignored.
REQ-024 Source k continuously valid SHALL be granted within N_REQ transfers (starvation-free).
REQ-025 o_reqReady SHALL not depend on i_reqPacket; no combinational path from i_reqPacket to any output.

Reset
REQ-026 While i_arst_n=0: o_packet=0, o_packetValid=0, o_grantIdx=0, ptr=0, o_reqReady=0 (forced, independent of i_reqValid).
REQ-027 Reset assertion mid-operation SHALL discard the held packet immediately (asynchronous); no packet is presented after reset release until a new transfer.
REQ-028 First cycle after reset release SHALL behave as loadEn=1, ptr=0.

Verification
REQ-029 Single source: reset, i_reqValid=5'b00100, packet 0x1A, i_packetReady=1 -> o_reqReady=5'b00100 same cycle; next cycle o_packet=0x1A, o_packetValid=1, o_grantIdx=2; ptr=3.
REQ-030 All sources valid continuously, i_packetReady=1 -> o_grantIdx sequence 0,1,2,3,4,0 on consecutive cycles, one packet per cycle.
REQ-031 Backpressure: o_packetValid=1 holding source 1, i_packetReady=0 for 3 cycles, sources 3 and 4 valid -> o_reqReady=0 and o_packet/o_grantIdx stable 3 cycles; when i_packetReady=1, source 3 granted same cycle, o_grantIdx=3 next cycle.
REQ-032 Wrap: ptr=4, i_reqValid=5'b10001 -> source 4 granted, ptr becomes 0; next cycle source 0 granted, ptr becomes 1.
REQ-033 Drain: single packet transferred, then i_reqValid=0, i_packetReady=1 -> next cycle o_packetValid=0, o_packet=0, o_grantIdx unchanged.
REQ-034 Reset mid-stall: o_packetValid=1, i_packetReady=0, assert i_arst_n=0 between clock edges -> o_packetValid=0, o_packet=0, o_reqReady=0 immediately; after release, grant search starts at source 0.
